// File: rtl/cnt_share_acc_array16.sv
// Unary-to-binary decoder array: counts ones per lane over a shared window of
// 2^CWID enabled samples and publishes all lane counts with a one-cycle valid.
module cnt_share_acc_array16 #(
  parameter int CWID = 10,
  parameter int BDIM = 1,
  parameter int TDIM = (BDIM < 1) ? 1 : BDIM,
  parameter int SDIM = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              clear,
  input  logic [TDIM*SDIM-1:0]              bitIn,
  output logic [TDIM*SDIM-1:0][CWID:0]      cntOut,
  output logic                              valid,
  output logic [CWID-1:0]                   phase
);

  localparam int N = TDIM * SDIM;

  logic [N-1:0]         bit_p1;
  logic [TDIM-1:0]      en_p1;
  logic [N-1:0][CWID:0] acc_p2;
  logic                 last_p2;

  function automatic logic [CWID:0] add_bit(input logic [CWID:0] a, input logic b);
    return a + {{CWID{1'b0}}, b};
  endfunction

  // Stage 1: input capture, one enable copy per buffer group
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_p1 <= '0;
      en_p1  <= '0;
    end else if (clear) begin
      bit_p1 <= '0;
      en_p1  <= '0;
    end else begin
      bit_p1 <= bitIn;
      en_p1  <= {TDIM{enable}};
    end
  end

  assign last_p2 = &phase;

  // Stage 2: shared window phase and close pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      phase <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en_p1[0] & last_p2;
      if (en_p1[0])
        phase <= phase + CWID'(1);
    end
  end

  // Stage 2: per-lane accumulate; the closing sample folds straight into cntOut
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2 <= '0;
      cntOut <= '0;
    end else if (clear) begin
      acc_p2 <= '0;
    end else begin
      for (int g = 0; g < TDIM; g++) begin
        for (int l = 0; l < SDIM; l++) begin
          if (en_p1[g]) begin
            if (last_p2) begin
              cntOut[g*SDIM+l] <= add_bit(acc_p2[g*SDIM+l], bit_p1[g*SDIM+l]);
              acc_p2[g*SDIM+l] <= '0;
            end else begin
              acc_p2[g*SDIM+l] <= add_bit(acc_p2[g*SDIM+l], bit_p1[g*SDIM+l]);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cnt_share_acc_array16.sv
// Randomized scoreboard bench for cnt_share_acc_array16 (CWID=4, two buffer groups).
module tb_cnt_share_acc_array16;

  localparam int CW  = 4;
  localparam int BD  = 2;
  localparam int SD  = 16;
  localparam int N   = BD * SD;
  localparam int WIN = 1 << CW;
  localparam int MAXC = 4096;

  typedef logic [N-1:0][CW:0] cnt_t;
  typedef struct {
    int   due;
    cnt_t cnt;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           clear;
  logic [N-1:0]   bitIn;
  cnt_t           cntOut;
  logic           valid;
  logic [CW-1:0]  phase;

  cnt_share_acc_array16 #(.CWID(CW), .BDIM(BD), .SDIM(SD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .bitIn(bitIn), .cntOut(cntOut), .valid(valid), .phase(phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: windows of accepted samples, expected pulses, expected phase
  exp_t          q[$];
  cnt_t          hold;
  cnt_t          win;
  cnt_t          pend_cnt;
  bit            pend;
  int            n;
  logic [CW-1:0] ph_exp [0:MAXC-1];
  bit            ph_v   [0:MAXC-1];
  int            n_chk  = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold = '0;
    win  = '0;
    n    = 0;
    pend = 1'b0;
  endtask

  // Present one cycle of stimulus and advance the model by that cycle
  task automatic step(input bit en, input bit clr, input logic [N-1:0] b);
    int   c;
    exp_t e;
    c = cyc;
    enable = en;
    clear  = clr;
    bitIn  = b;
    if (pend) begin
      if (!clr) begin
        e.due = c + 1;
        e.cnt = pend_cnt;
        q.push_back(e);
      end
      pend = 1'b0;
    end
    if (c + 1 < MAXC) begin
      ph_exp[c+1] = clr ? '0 : CW'(n);
      ph_v[c+1]   = 1'b1;
    end
    if (clr) begin
      n   = 0;
      win = '0;
    end else if (en) begin
      for (int k = 0; k < N; k++) win[k] = win[k] + (CW+1)'(b[k]);
      n++;
      if (n == WIN) begin
        pend     = 1'b1;
        pend_cnt = win;
        win      = '0;
        n        = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_rst();
    enable = 1'b0;
    clear  = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_cnt", cntOut, '0);
    chk("rst_valid", valid, 0);
    chk("rst_phase", phase, 0);
    model_reset();
    for (int i = 0; i < 3; i++) if (cyc + i < MAXC) ph_v[cyc+i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] pat(input int s, input int w);
    logic [N-1:0] b;
    int cnt;
    for (int k = 0; k < N; k++) begin
      cnt  = (w == 0) ? (k % 17) : ((k * 3) % 17);
      b[k] = (((s + k) % WIN) < cnt);
    end
    return b;
  endfunction

  // Monitor: pops the scoreboard when a pulse is due, else checks hold/idle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("valid_pulse", valid, 1);
        chk("window_cnt", cntOut, e.cnt);
        hold = e.cnt;
      end else begin
        chk("valid_idle", valid, 0);
        chk("cnt_hold", cntOut, hold);
      end
      if (cyc < MAXC && ph_v[cyc]) chk("phase", phase, ph_exp[cyc]);
    end
  end

  initial begin
    logic [N-1:0] b;
    for (int i = 0; i < MAXC; i++) ph_v[i] = 1'b0;
    model_reset();
    rst = 1'b1; enable = 1'b0; clear = 1'b0; bitIn = '0;
    repeat (2) @(negedge clk);
    chk("reset_cnt", cntOut, '0);
    chk("reset_valid", valid, 0);
    chk("reset_phase", phase, 0);
    rst = 1'b0;
    @(negedge clk);

    // lane 0 constant one, lane 1 constant zero, two windows
    for (int s = 0; s < 2*WIN; s++) begin
      b = N'($urandom());
      b[0] = 1'b1;
      b[1] = 1'b0;
      step(1, 0, b);
    end
    // per-lane ones counts, two back-to-back windows with different patterns
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < WIN; s++) step(1, 0, pat(s, w));
    // alternating enable, all ones
    for (int s = 0; s < 2*WIN; s++) step(s % 2 == 0, 0, '1);
    repeat (3) step(0, 0, '0);
    // clear after 7 samples, then a full window
    for (int s = 0; s < 7; s++) step(1, 0, '1);
    step(1, 1, '1);
    for (int s = 0; s < WIN; s++) step(1, 0, N'($urandom()));
    repeat (3) step(0, 0, '0);
    // clear coincident with the 16th sample
    for (int s = 0; s < WIN-1; s++) step(1, 0, '1);
    step(1, 1, '1);
    repeat (3) step(0, 0, '0);
    // clear in the cycle the window would close
    for (int s = 0; s < WIN; s++) step(1, 0, N'($urandom()));
    step(0, 1, '0);
    repeat (3) step(0, 0, '0);
    // asynchronous reset mid-window, then a full window
    for (int s = 0; s < 5; s++) step(1, 0, N'($urandom()));
    do_rst();
    for (int s = 0; s < WIN; s++) step(1, 0, N'($urandom()));
    repeat (3) step(0, 0, '0);
    // randomized traffic
    for (int s = 0; s < 400; s++)
      step($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0, N'($urandom()));
    repeat (5) step(0, 0, '0);
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
